spi_request_arbiter: RTL and testbench

Round-robin scheduler that shares one `quick_spi` master between up to `NUMBER_OF_REQUESTERS` client blocks. It latches the winning request, drives the master's command inputs stable for the whole transaction, and returns the master's read data to the granted client. It also guards against a hung master with a timeout. It sits directly in front of `quick_spi`; clients never touch the master ports.

---
 rtl/spi_request_arbiter_if.sv | 25 ++
 rtl/spi_request_arbiter.sv | 140 ++++++++++++++
 tb/tb_spi_request_arbiter.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_request_arbiter_if.sv
// Command/response bus between the request arbiter and the quick_spi master.
// The master modport is the arbiter side; the slave modport is the quick_spi side.
interface spi_request_arbiter_if #(
    parameter int NUMBER_OF_SLAVES    = 2,
    parameter int INCOMING_DATA_WIDTH = 8,
    parameter int OUTGOING_DATA_WIDTH = 16
);
    logic                           spi_enable;
    logic                           spi_start_transaction;
    logic                           spi_operation;
    logic [NUMBER_OF_SLAVES-1:0]    spi_slave;
    logic [OUTGOING_DATA_WIDTH-1:0] spi_outgoing_data;
    logic                           spi_end_of_transaction;
    logic [INCOMING_DATA_WIDTH-1:0] spi_incoming_data;

    modport master (
        output spi_enable, spi_start_transaction, spi_operation, spi_slave, spi_outgoing_data,
        input  spi_end_of_transaction, spi_incoming_data
    );

    modport slave (
        input  spi_enable, spi_start_transaction, spi_operation, spi_slave, spi_outgoing_data,
        output spi_end_of_transaction, spi_incoming_data
    );
endinterface

// File: rtl/spi_request_arbiter.sv
// Round-robin arbiter sharing one quick_spi master between several clients,
// holding the winner's command stable for the whole transaction, with a hang timeout.
module spi_request_arbiter #(
    parameter int NUMBER_OF_REQUESTERS = 4,
    parameter int NUMBER_OF_SLAVES     = 2,
    parameter int INCOMING_DATA_WIDTH  = 8,
    parameter int OUTGOING_DATA_WIDTH  = 16,
    parameter int TIMEOUT_CYCLES       = 1024
) (
    input  logic                                            clk,
    input  logic                                            reset_n,
    input  logic [NUMBER_OF_REQUESTERS-1:0]                 req,
    input  logic [NUMBER_OF_REQUESTERS-1:0]                 req_operation,
    input  logic [NUMBER_OF_REQUESTERS*NUMBER_OF_SLAVES-1:0]    req_slave,
    input  logic [NUMBER_OF_REQUESTERS*OUTGOING_DATA_WIDTH-1:0] req_outgoing_data,
    output logic [NUMBER_OF_REQUESTERS-1:0]                 grant,
    output logic [NUMBER_OF_REQUESTERS-1:0]                 done,
    output logic [INCOMING_DATA_WIDTH-1:0]                  rsp_incoming_data,
    output logic                                            timeout_error,
    spi_request_arbiter_if.master                           spi
);

    localparam int IDX_W = $clog2(NUMBER_OF_REQUESTERS);
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, COMPLETE} state_t;

    state_t                         state;
    state_t                         state_next;
    logic [IDX_W-1:0]               last;
    logic [IDX_W-1:0]               current;
    logic [IDX_W-1:0]               winner;
    logic                           found;
    int                             cand;
    logic [CNT_W-1:0]               timeout_count;
    logic                           timeout_hit;
    logic                           enable_q;
    logic                           start_q;
    logic                           operation_q;
    logic [NUMBER_OF_SLAVES-1:0]    slave_q;
    logic [OUTGOING_DATA_WIDTH-1:0] outgoing_q;

    // Search starts just after the previous winner, so the last served client ranks lowest.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = 0;
        for (int k = 1; k <= NUMBER_OF_REQUESTERS; k++) begin
            cand = int'(last) + k;
            if (cand >= NUMBER_OF_REQUESTERS) cand = cand - NUMBER_OF_REQUESTERS;
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = IDX_W'(cand);
            end
        end
    end

    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (timeout_count == TIMEOUT_LAST);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (found) state_next = ISSUE;
            ISSUE:    state_next = BUSY;
            BUSY:     if (spi.spi_end_of_transaction || timeout_hit) state_next = COMPLETE;
            COMPLETE: state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // The end-of-transaction response wins over a timeout landing in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last              <= IDX_W'(NUMBER_OF_REQUESTERS - 1);
            current           <= '0;
            grant             <= '0;
            done              <= '0;
            rsp_incoming_data <= '0;
            timeout_error     <= 1'b0;
            timeout_count     <= '0;
            enable_q          <= 1'b0;
            start_q           <= 1'b0;
            operation_q       <= 1'b0;
            slave_q           <= '0;
            outgoing_q        <= '0;
        end else begin
            enable_q      <= 1'b1;
            start_q       <= 1'b0;
            done          <= '0;
            timeout_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant         <= '0;
                        grant[winner] <= 1'b1;
                        current       <= winner;
                        operation_q   <= req_operation[winner];
                        slave_q       <= req_slave[winner*NUMBER_OF_SLAVES +: NUMBER_OF_SLAVES];
                        outgoing_q    <= req_outgoing_data[winner*OUTGOING_DATA_WIDTH +: OUTGOING_DATA_WIDTH];
                    end
                end
                ISSUE: begin
                    start_q       <= 1'b1;
                    timeout_count <= '0;
                end
                BUSY: begin
                    if (spi.spi_end_of_transaction) begin
                        rsp_incoming_data <= spi.spi_incoming_data;
                        done[current]     <= 1'b1;
                    end else if (timeout_hit) begin
                        rsp_incoming_data <= '0;
                        done[current]     <= 1'b1;
                        timeout_error     <= 1'b1;
                    end else if (timeout_count != CNT_MAX) begin
                        timeout_count <= timeout_count + 1'b1;
                    end
                end
                COMPLETE: begin
                    grant <= '0;
                    last  <= current;
                end
                default: ;
            endcase
        end
    end

    assign spi.spi_enable            = enable_q;
    assign spi.spi_start_transaction = start_q;
    assign spi.spi_operation         = operation_q;
    assign spi.spi_slave             = slave_q;
    assign spi.spi_outgoing_data     = outgoing_q;

endmodule

// File: tb/tb_spi_request_arbiter.sv
// Self-checking bench for spi_request_arbiter: a behavioural quick_spi responder plus
// a round-robin reference that predicts each grant from the sampled request vector.
module tb_spi_request_arbiter;

    localparam int N  = 4;
    localparam int NS = 2;
    localparam int IW = 8;
    localparam int OW = 16;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [N-1:0]  req;
    logic [N-1:0]  req_operation;
    logic [N*NS-1:0] req_slave;
    logic [N*OW-1:0] req_outgoing_data;
    logic [N-1:0]  grant;
    logic [N-1:0]  done;
    logic [IW-1:0] rsp_incoming_data;
    logic          timeout_error;

    spi_request_arbiter_if #(.NUMBER_OF_SLAVES(NS), .INCOMING_DATA_WIDTH(IW),
                             .OUTGOING_DATA_WIDTH(OW)) spi ();

    spi_request_arbiter #(
        .NUMBER_OF_REQUESTERS(N), .NUMBER_OF_SLAVES(NS), .INCOMING_DATA_WIDTH(IW),
        .OUTGOING_DATA_WIDTH(OW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_operation(req_operation),
        .req_slave(req_slave), .req_outgoing_data(req_outgoing_data), .grant(grant),
        .done(done), .rsp_incoming_data(rsp_incoming_data), .timeout_error(timeout_error),
        .spi(spi)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int ref_last = N - 1;
    int log_idx = 0;

    bit            model_hang = 1'b0;
    int            model_delay_lo = 0;
    int            model_delay_hi = 3;
    bit            force_en = 1'b0;
    logic [IW-1:0] force_data = '0;
    int            stray_count = 0;
    logic [IW-1:0] model_log[$];

    // Responder: sees the start pulse, waits a random delay, returns one word for one cycle.
    initial begin
        int stray_seen;
        int d;
        logic [IW-1:0] v;
        stray_seen = 0;
        spi.spi_end_of_transaction = 1'b0;
        spi.spi_incoming_data = '0;
        forever begin
            @(negedge clk);
            if (stray_count != stray_seen) begin
                stray_seen = stray_count;
                spi.spi_end_of_transaction = 1'b1;
                spi.spi_incoming_data = 8'h77;
                @(negedge clk);
                spi.spi_end_of_transaction = 1'b0;
                spi.spi_incoming_data = '0;
            end else if (spi.spi_start_transaction && !model_hang) begin
                d = int'($urandom_range(model_delay_hi, model_delay_lo));
                repeat (d) @(negedge clk);
                v = force_en ? force_data : IW'($urandom);
                model_log.push_back(v);
                spi.spi_end_of_transaction = 1'b1;
                spi.spi_incoming_data = v;
                @(negedge clk);
                spi.spi_end_of_transaction = 1'b0;
                spi.spi_incoming_data = '0;
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int ref_winner(input logic [N-1:0] r);
        int c;
        for (int k = 1; k <= N; k++) begin
            c = (ref_last + k) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] g;
        g = '0;
        if (i >= 0 && i < N) g[i] = 1'b1;
        return g;
    endfunction

    function automatic logic [IW-1:0] logged(input int i);
        if (i < model_log.size()) return model_log[i];
        return 'x;
    endfunction

    task automatic wait_grant(input int budget, output int cycles);
        cycles = -1;
        for (int i = 1; i <= budget && cycles < 0; i++) begin
            @(negedge clk);
            if (grant != '0) cycles = i;
        end
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = -1;
        for (int i = 1; i <= budget && cycles < 0; i++) begin
            @(negedge clk);
            if (done != '0) cycles = i;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req = '0;
        req_operation = '0;
        req_slave = '0;
        req_outgoing_data = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({grant, done, timeout_error} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_status: got grant=%b done=%b te=%b expected all 0", grant, done, timeout_error);
        end
        checks++;
        if ({spi.spi_enable, spi.spi_start_transaction, spi.spi_operation, spi.spi_slave,
             spi.spi_outgoing_data, rsp_incoming_data} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_bus: got en=%b st=%b slave=%h data=%h rsp=%h expected all 0",
                     spi.spi_enable, spi.spi_start_transaction, spi.spi_slave, spi.spi_outgoing_data, rsp_incoming_data);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (spi.spi_enable !== 1'b1 || grant !== '0) begin
            fails++;
            $display("[TB] FAIL reset_release: got en=%b grant=%b expected en=1 grant=0000", spi.spi_enable, grant);
        end
        ref_last = N - 1;
    endtask

    task automatic test_rounds(input string name, input int rounds, input bit hold_all);
        int c;
        int exp;
        logic [N-1:0] eg;
        model_delay_lo = 0;
        model_delay_hi = 5;
        req_operation = N'($urandom);
        req_slave = (N*NS)'($urandom);
        req_outgoing_data = (N*OW)'({$urandom, $urandom});
        for (int t = 0; t < rounds; t++) begin
            if (hold_all) begin
                req = '1;
            end else begin
                req = N'($urandom_range(15, 1));
                req_operation = N'($urandom);
                req_slave = (N*NS)'($urandom);
                req_outgoing_data = (N*OW)'({$urandom, $urandom});
            end
            wait_grant(8, c);
            exp = ref_winner(req);
            eg = onehot(exp);
            checks++;
            if (c < 0 || grant !== eg) begin
                fails++;
                $display("[TB] FAIL %s_grant round %0d: got %b expected %b", name, t, grant, eg);
            end
            checks++;
            if ({spi.spi_operation, spi.spi_slave, spi.spi_outgoing_data} !==
                {req_operation[exp], req_slave[exp*NS +: NS], req_outgoing_data[exp*OW +: OW]}) begin
                fails++;
                $display("[TB] FAIL %s_fields round %0d: got op=%b slave=%h data=%h expected client %0d fields",
                         name, t, spi.spi_operation, spi.spi_slave, spi.spi_outgoing_data, exp);
            end
            ref_last = exp;
            wait_done(40, c);
            checks++;
            if (c < 0 || done !== eg || rsp_incoming_data !== logged(log_idx) || timeout_error !== 1'b0) begin
                fails++;
                $display("[TB] FAIL %s_done round %0d: got done=%b rsp=%h te=%b expected done=%b rsp=%h te=0",
                         name, t, done, rsp_incoming_data, timeout_error, eg, logged(log_idx));
            end
            log_idx++;
            @(negedge clk);
            checks++;
            if (done !== '0) begin
                fails++;
                $display("[TB] FAIL %s_done_pulse round %0d: got %b expected 0000", name, t, done);
            end
        end
        req = '0;
    endtask

    task automatic test_single_read();
        int c;
        int starts;
        bit stable;
        bit got;
        model_delay_lo = 2;
        model_delay_hi = 2;
        force_en = 1'b1;
        force_data = 8'h3C;
        req_operation[2] = 1'b0;
        req_slave[2*NS +: NS] = 2'd1;
        req_outgoing_data[2*OW +: OW] = 16'hA55A;
        req = 4'b0100;
        wait_grant(8, c);
        checks++;
        if (c < 0 || grant !== 4'b0100) begin
            fails++;
            $display("[TB] FAIL read_grant: got %b expected 0100", grant);
        end
        checks++;
        if (spi.spi_operation !== 1'b0 || spi.spi_slave !== 2'd1 || spi.spi_outgoing_data !== 16'hA55A
            || spi.spi_start_transaction !== 1'b0) begin
            fails++;
            $display("[TB] FAIL read_fields: got op=%b slave=%h data=%h st=%b expected 0 1 a55a 0",
                     spi.spi_operation, spi.spi_slave, spi.spi_outgoing_data, spi.spi_start_transaction);
        end
        ref_last = 2;
        req = '0;
        @(negedge clk);
        checks++;
        if (spi.spi_start_transaction !== 1'b1) begin
            fails++;
            $display("[TB] FAIL read_start: got %b expected 1", spi.spi_start_transaction);
        end
        starts = 1;
        stable = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (spi.spi_start_transaction) starts++;
            if (spi.spi_slave !== 2'd1 || spi.spi_outgoing_data !== 16'hA55A || spi.spi_operation !== 1'b0) stable = 1'b0;
            if (done != '0) got = 1'b1;
        end
        checks++;
        if (!got || starts != 1 || !stable) begin
            fails++;
            $display("[TB] FAIL read_busy: got done_seen=%0d starts=%0d stable=%0d expected 1 1 1", got, starts, stable);
        end
        checks++;
        if (done !== 4'b0100 || rsp_incoming_data !== 8'h3C || timeout_error !== 1'b0) begin
            fails++;
            $display("[TB] FAIL read_done: got done=%b rsp=%h te=%b expected 0100 3c 0", done, rsp_incoming_data, timeout_error);
        end
        log_idx++;
        force_en = 1'b0;
        @(negedge clk);
        checks++;
        if (grant !== '0 || rsp_incoming_data !== 8'h3C) begin
            fails++;
            $display("[TB] FAIL read_after: got grant=%b rsp=%h expected 0000 3c", grant, rsp_incoming_data);
        end
    endtask

    task automatic test_withdraw();
        int c;
        bit saw1;
        model_delay_lo = 8;
        model_delay_hi = 8;
        req = 4'b0001;
        wait_grant(8, c);
        checks++;
        if (c < 0 || grant !== onehot(ref_winner(4'b0001))) begin
            fails++;
            $display("[TB] FAIL withdraw_first: got %b expected 0001", grant);
        end
        ref_last = 0;
        req = '0;
        @(negedge clk);
        req[1] = 1'b1;
        req[3] = 1'b1;
        saw1 = 1'b0;
        repeat (2) @(negedge clk);
        req[1] = 1'b0;
        wait_done(30, c);
        if (grant[1]) saw1 = 1'b1;
        checks++;
        if (c < 0 || done !== 4'b0001) begin
            fails++;
            $display("[TB] FAIL withdraw_done: got %b expected 0001", done);
        end
        log_idx++;
        wait_grant(8, c);
        if (grant[1]) saw1 = 1'b1;
        checks++;
        if (c < 0 || grant !== onehot(ref_winner(req)) || saw1) begin
            fails++;
            $display("[TB] FAIL withdraw_next: got %b expected %b", grant, onehot(ref_winner(req)));
        end
        ref_last = 3;
        req = '0;
        wait_done(30, c);
        log_idx++;
        @(negedge clk);
    endtask

    task automatic test_stray_eot();
        logic [IW-1:0] rb;
        bit clean;
        int c;
        rb = rsp_incoming_data;
        stray_count++;
        clean = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done !== '0 || grant !== '0 || spi.spi_start_transaction !== 1'b0) clean = 1'b0;
        end
        checks++;
        if (!clean || rsp_incoming_data !== rb) begin
            fails++;
            $display("[TB] FAIL stray_eot: got clean=%0d rsp=%h expected 1 %h", clean, rsp_incoming_data, rb);
        end
        model_delay_lo = 1;
        model_delay_hi = 1;
        req = 4'b0010;
        wait_grant(1, c);
        checks++;
        if (c != 1 || grant !== 4'b0010) begin
            fails++;
            $display("[TB] FAIL stray_then_grant: got %b after %0d expected 0010 after 1", grant, c);
        end
        ref_last = 1;
        req = '0;
        wait_done(20, c);
        log_idx++;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int c;
        int cycles;
        model_hang = 1'b1;
        req = 4'b0010;
        wait_grant(8, c);
        req = '0;
        @(negedge clk);
        checks++;
        if (c < 0 || grant !== 4'b0010 || spi.spi_start_transaction !== 1'b1) begin
            fails++;
            $display("[TB] FAIL timeout_issue: got grant=%b st=%b expected 0010 1", grant, spi.spi_start_transaction);
        end
        wait_done(40, cycles);
        checks++;
        if (cycles != TO) begin
            fails++;
            $display("[TB] FAIL timeout_latency: got %0d cycles expected %0d", cycles, TO);
        end
        checks++;
        if (done !== 4'b0010 || timeout_error !== 1'b1 || rsp_incoming_data !== '0) begin
            fails++;
            $display("[TB] FAIL timeout_done: got done=%b te=%b rsp=%h expected 0010 1 00", done, timeout_error, rsp_incoming_data);
        end
        @(negedge clk);
        checks++;
        if (timeout_error !== 1'b0 || grant !== '0) begin
            fails++;
            $display("[TB] FAIL timeout_pulse: got te=%b grant=%b expected 0 0000", timeout_error, grant);
        end
        ref_last = 1;
        model_hang = 1'b0;
        req = 4'b0100;
        wait_grant(8, c);
        checks++;
        if (c < 0 || grant !== 4'b0100) begin
            fails++;
            $display("[TB] FAIL timeout_resume: got %b expected 0100", grant);
        end
        ref_last = 2;
        req = '0;
        wait_done(20, c);
        log_idx++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_busy();
        int c;
        bit saw_done;
        model_hang = 1'b1;
        req_operation[2] = 1'b1;
        req_slave[2*NS +: NS] = 2'd3;
        req_outgoing_data[2*OW +: OW] = 16'hFFFF;
        req = 4'b0100;
        wait_grant(8, c);
        req = '0;
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({grant, done, timeout_error, rsp_incoming_data, spi.spi_enable, spi.spi_start_transaction,
             spi.spi_operation, spi.spi_slave, spi.spi_outgoing_data} !== '0) begin
            fails++;
            $display("[TB] FAIL async_reset: got grant=%b en=%b op=%b slave=%h data=%h expected all 0",
                     grant, spi.spi_enable, spi.spi_operation, spi.spi_slave, spi.spi_outgoing_data);
        end
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done !== '0) saw_done = 1'b1;
        end
        reset_n = 1'b1;
        model_hang = 1'b0;
        ref_last = N - 1;
        req = '1;
        wait_grant(8, c);
        if (done !== '0) saw_done = 1'b1;
        checks++;
        if (c < 0 || grant !== onehot(ref_winner(req)) || spi.spi_enable !== 1'b1 || saw_done) begin
            fails++;
            $display("[TB] FAIL reset_priority: got grant=%b en=%b stray_done=%0d expected 0001 1 0",
                     grant, spi.spi_enable, saw_done);
        end
        ref_last = 0;
        req = '0;
        wait_done(20, c);
        checks++;
        if (c < 0 || done !== 4'b0001) begin
            fails++;
            $display("[TB] FAIL reset_followup: got %b expected 0001", done);
        end
        log_idx++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_rounds("fairness", 8, 1'b1);
        test_single_read();
        test_withdraw();
        test_rounds("random", 10, 1'b0);
        test_stray_eot();
        test_timeout();
        test_reset_mid_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
